// File: rtl/cwd_string_server.sv
// rtl/cwd_string_server.sv - streams the captured CWD string to one of two requesters
//
// Purpose:
//   Arbitrates round-robin between two requesters. On a grant it snapshots
//   the CWD vector and its length-error flag, skips the leading null padding,
//   then streams the remaining bytes one per handshake. A 0x00 terminator
//   beat (out_last=1) ends each transfer and carries the length-error flag.
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset
//   cwd        packed CWD, byte k = cwd[8k:8k+7], byte 0 leftmost
//   len_err    reader overflow flag
//   req        request per requester
//   gnt        one-hot grant, held for the whole transfer
//   out_data   current character
//   out_valid  out_data valid
//   out_ready  consumer accepts
//   out_last   marks the terminator beat
//   out_err    len_err snapshot, valid only on the terminator beat
//   busy       transfer in progress (state is not IDLE)

module cwd_string_server #(
  parameter int length = 100
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [0:length*8-1]   cwd,
  input  logic                  len_err,
  input  logic [1:0]            req,
  output logic [1:0]            gnt,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  out_err,
  output logic                  busy
);

  localparam int IW = $clog2(length + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_SEND,
    S_TERM
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          gnt_q, gnt_d;
  logic                last_q, last_d;     // index of the requester granted last
  logic [0:length*8-1] snap_q, snap_d;
  logic                err_snap_q, err_snap_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [7:0]          out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic                out_err_q, out_err_d;

  logic [7:0]          cur_byte;
  logic [7:0]          nxt_byte;
  logic                win;

  // Byte at idx and at idx+1 from the snapshot. Index values past the end
  // (idx==length while scanning) simply match nothing and read as 0x00.
  always_comb begin
    cur_byte = 8'h00;
    nxt_byte = 8'h00;
    for (int k = 0; k < length; k++) begin
      if (idx_q == IW'(k)) begin
        cur_byte = snap_q[k*8 +: 8];
      end
      if ((idx_q + IW'(1)) == IW'(k)) begin
        nxt_byte = snap_q[k*8 +: 8];
      end
    end
  end

  // On a tie the requester that was not served last wins; a lone requester
  // always wins.
  always_comb begin
    if (req == 2'b11) begin
      win = ~last_q;
    end else begin
      win = req[1];
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    snap_d      = snap_q;
    err_snap_d  = err_snap_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_err_d   = out_err_q;

    case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          gnt_d      = win ? 2'b10 : 2'b01;
          last_d     = win;
          snap_d     = cwd;
          err_snap_d = len_err;
          idx_d      = '0;
          state_d    = S_SCAN;
        end
      end

      S_SCAN: begin
        if (idx_q == IW'(length)) begin
          state_d     = S_TERM;
          out_valid_d = 1'b1;
          out_data_d  = 8'h00;
          out_last_d  = 1'b1;
          out_err_d   = err_snap_q;
        end else if (cur_byte != 8'h00) begin
          state_d     = S_SEND;
          out_valid_d = 1'b1;
          out_data_d  = cur_byte;
          out_last_d  = 1'b0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end

      S_SEND: begin
        // Once the first non-null byte is found every remaining byte is
        // sent verbatim, embedded nulls included.
        if (out_ready) begin
          if (idx_q == IW'(length - 1)) begin
            state_d     = S_TERM;
            out_data_d  = 8'h00;
            out_last_d  = 1'b1;
            out_err_d   = err_snap_q;
          end else begin
            idx_d      = idx_q + IW'(1);
            out_data_d = nxt_byte;
          end
        end
      end

      S_TERM: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          gnt_d       = 2'b00;
          out_valid_d = 1'b0;
          out_data_d  = 8'h00;
          out_last_d  = 1'b0;
          out_err_d   = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      gnt_q       <= 2'b00;
      last_q      <= 1'b1;
      err_snap_q  <= 1'b0;
      idx_q       <= '0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      err_snap_q  <= err_snap_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_err_q   <= out_err_d;
    end
  end

  // The snapshot is only read after a grant has loaded it, so it needs no reset.
  always_ff @(posedge clk) begin
    snap_q <= snap_d;
  end

  assign gnt       = gnt_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_err   = out_err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_cwd_string_server.sv
// tb/tb_cwd_string_server.sv - self-checking bench for cwd_string_server

module tb_cwd_string_server;

  localparam int LEN = 8;

  logic               clk = 1'b0;
  logic               reset;
  logic [0:LEN*8-1]   cwd;
  logic               len_err;
  logic [1:0]         req;
  logic [1:0]         gnt;
  logic [7:0]         out_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;
  logic               out_err;
  logic               busy;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: the CWD bytes and error flag offered to the DUT,
  // and the index of the requester that was served last.
  logic [7:0] mb [LEN];
  logic       merr;
  int         last_gnt = 1;

  cwd_string_server #(.length(LEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .cwd       (cwd),
    .len_err   (len_err),
    .req       (req),
    .gnt       (gnt),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out_err   (out_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_cwd();
    for (int k = 0; k < LEN; k++) cwd[k*8 +: 8] = mb[k];
    len_err = merr;
  endtask

  function automatic logic [1:0] model_grant(input logic [1:0] r);
    int w;
    if (r == 2'b11) w = 1 - last_gnt;
    else            w = r[1] ? 1 : 0;
    last_gnt = w;
    return (w == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic set_str(input string s, input logic e);
    for (int k = 0; k < LEN; k++) mb[k] = 8'h00;
    for (int k = 0; k < s.len(); k++) mb[LEN - s.len() + k] = s[k];
    merr = e;
  endtask

  // One complete transfer: request, grant, leading-null latency, every beat
  // against the expected stream, stall stability, and the trailing IDLE cycle.
  task automatic transfer(input string tag, input logic [1:0] r, input bit rand_rdy);
    logic [7:0] q_data [$];
    bit         q_last [$];
    int         n;
    int         waited;
    bit         done;
    bit         stalled;
    logic [7:0] hold;
    logic [1:0] eg;

    n = 0;
    while (n < LEN && mb[n] == 8'h00) n++;
    for (int k = n; k < LEN; k++) begin
      q_data.push_back(mb[k]);
      q_last.push_back(1'b0);
    end
    q_data.push_back(8'h00);
    q_last.push_back(1'b1);
    eg = model_grant(r);

    load_cwd();
    req       = r;
    out_ready = 1'b1;
    tick();
    check({tag, " gnt"}, 32'(gnt), 32'(eg));
    check({tag, " busy"}, 32'(busy), 32'd1);

    // The stream must come from the snapshot, not the live input.
    cwd     = {$urandom, $urandom};
    len_err = ~merr;

    waited = 1;
    while (out_valid !== 1'b1 && waited < 40) begin
      tick();
      waited++;
    end
    check({tag, " first_valid_latency"}, 32'(waited), 32'(2 + n));

    done    = 1'b0;
    stalled = 1'b0;
    waited  = 0;
    while (!done && waited < 200) begin
      if (stalled) check({tag, " stall_stable"}, 32'(out_data), 32'(hold));
      check({tag, " valid_held"}, 32'(out_valid), 32'd1);
      if (out_valid !== 1'b1) break;
      req       = 2'($urandom);
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_ready) begin
        check({tag, " data"}, 32'(out_data), 32'(q_data[0]));
        check({tag, " last"}, 32'(out_last), 32'(q_last[0]));
        check({tag, " err"},  32'(out_err),  32'(q_last[0] ? merr : 1'b0));
        if (q_last[0]) done = 1'b1;
        void'(q_data.pop_front());
        void'(q_last.pop_front());
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        hold    = out_data;
      end
      tick();
      waited++;
    end
    check({tag, " terminator_seen"}, 32'(done), 32'd1);
    check({tag, " gnt_cleared"},     32'(gnt),       32'd0);
    check({tag, " valid_cleared"},   32'(out_valid), 32'd0);
    check({tag, " idle_gap"},        32'(busy),      32'd0);
    req       = r;
    out_ready = 1'b1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req       = 2'b00;
    out_ready = 1'b1;
    tick();
    tick();
    reset    = 1'b0;
    last_gnt = 1;
  endtask

  initial begin
    cwd       = '0;
    len_err   = 1'b0;
    req       = 2'b00;
    out_ready = 1'b0;
    merr      = 1'b0;
    do_reset();

    check("rst gnt",       32'(gnt),       32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_last",  32'(out_last),  32'd0);
    check("rst out_err",   32'(out_err),   32'd0);
    check("rst out_data",  32'(out_data),  32'd0);
    check("rst busy",      32'(busy),      32'd0);

    // "/tmp" behind four nulls, single requester.
    set_str("/tmp", 1'b0);
    transfer("tmp_single", 2'b01, 1'b0);
    req = 2'b00;
    tick();

    // Both requesting from reset: grants alternate starting with requester 0.
    do_reset();
    for (int t = 0; t < 4; t++) transfer("rr_both", 2'b11, 1'b0);
    req = 2'b00;
    tick();

    // All-null CWD: full scan then a lone terminator.
    set_str("", 1'b0);
    transfer("all_null", 2'b10, 1'b0);
    req = 2'b00;
    tick();

    // No padding with length error flagged.
    set_str("abcdefgh", 1'b1);
    transfer("no_pad_err", 2'b01, 1'b0);
    req = 2'b00;
    tick();

    // Random back-pressure.
    set_str("/tmp", 1'b0);
    for (int t = 0; t < 3; t++) transfer("tmp_stall", 2'b01, 1'b1);
    req = 2'b00;
    tick();

    // Reset while the second character is on the bus.
    set_str("/tmp", 1'b0);
    load_cwd();
    req = 2'b01;
    tick();
    req = 2'b00;
    for (int w = 0; w < 20 && out_valid !== 1'b1; w++) tick();
    tick();
    check("mid_rst second_char", 32'(out_data), 32'h74);
    reset = 1'b1;
    tick();
    check("mid_rst gnt",       32'(gnt),       32'd0);
    check("mid_rst out_valid", 32'(out_valid), 32'd0);
    check("mid_rst busy",      32'(busy),      32'd0);
    check("mid_rst out_last",  32'(out_last),  32'd0);
    reset    = 1'b0;
    last_gnt = 1;
    tick();
    transfer("after_rst", 2'b01, 1'b0);
    req = 2'b00;
    tick();

    // Randomized transfers against the model.
    for (int t = 0; t < 20; t++) begin
      int lead;
      logic [1:0] r;
      lead = $urandom_range(0, LEN);
      merr = 1'($urandom_range(0, 3) == 0);
      if (merr) lead = 0;
      for (int k = 0; k < LEN; k++) begin
        if (k < lead)                    mb[k] = 8'h00;
        else if (k == lead)              mb[k] = 8'($urandom_range(1, 255));
        else if ($urandom_range(0, 4) == 0) mb[k] = 8'h00;
        else                             mb[k] = 8'($urandom_range(1, 255));
      end
      r = 2'($urandom_range(1, 3));
      transfer("random", r, 1'b1);
      req = 2'b00;
      if ($urandom_range(0, 1) == 1) tick();
    end

    req = 2'b00;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
